// File: rtl/cpu_pkg.sv
// Shared core definitions: widths, opcodes and fetch states.
// Imported by the fetch stage and its PC register.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_INST_W = 16;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: hold, increment with wrap, redirect or predecoded jmp.
// Ports: clk_i, rst_i, advance_i, redirect_valid_i/redirect_pc_i,
//        jmp_hit_i/jmp_tgt_i, pc_o.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              jmp_hit_i,
    input  logic [ADDR_W-1:0] jmp_tgt_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Redirect beats everything; PC+1 wraps naturally at ADDR_W bits.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = jmp_hit_i ? jmp_tgt_i : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC -> ROM -> IR, valid/ready hand-off to decode, redirects.
// Ports: clk, rst, fetch_en, rom_address/rom_inst, ir_valid/ir_ready, ir,
//        ir_pc, ir_jmp_taken, redirect_valid/redirect_pc, fetch_count.
// Define FETCH_PREDECODE_EN to redirect jmp in fetch with no bubble.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int         ADDR_W     = CPU_ADDR_W,
    parameter int         INST_W     = CPU_INST_W,
    parameter int         RESET_PC   = 0,
    parameter logic [3:0] JMP_OPCODE = OP_JMP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [INST_W-1:0] rom_inst,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_jmp_taken,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       fetch_count
);

`ifdef FETCH_PREDECODE_EN
    localparam bit PREDECODE = 1'b1;
`else
    localparam bit PREDECODE = 1'b0;
`endif

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              ir_jmp_q, ir_jmp_d;
    logic [15:0]       count_q, count_d;

    logic [ADDR_W-1:0] pc;
    logic              slot_open;
    logic              do_fetch;
    logic              xfer;
    logic              jmp_hit;
    logic [ADDR_W-1:0] jmp_tgt;

    assign slot_open = !ir_valid_q || ir_ready;
    assign do_fetch  = fetch_en && slot_open && !redirect_valid;
    assign xfer      = ir_valid_q && ir_ready;
    assign jmp_hit   = PREDECODE && (rom_inst[15:12] == JMP_OPCODE);
    assign jmp_tgt   = ADDR_W'(rom_inst[11:8]);

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i            (clk),
        .rst_i            (rst),
        .advance_i        (do_fetch),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .jmp_hit_i        (jmp_hit),
        .jmp_tgt_i        (jmp_tgt),
        .pc_o             (pc)
    );

    always_comb begin
        state_d = state_q;
        if (!fetch_en && !ir_valid_q) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = RUN;
                end
                RUN: begin
                    if (ir_valid_q && !ir_ready && !redirect_valid)
                        state_d = STALL;
                end
                STALL: begin
                    if (ir_ready || redirect_valid) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A consumed IR is counted even when a redirect flushes that cycle.
    always_comb begin
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        ir_jmp_d   = ir_jmp_q;
        count_d    = count_q;
        if (xfer && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
        if (redirect_valid) begin
            ir_valid_d = 1'b0;
            ir_jmp_d   = 1'b0;
        end else if (do_fetch) begin
            ir_d       = rom_inst;
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
            ir_jmp_d   = jmp_hit;
        end else if (ir_ready) begin
            ir_valid_d = 1'b0;
            ir_jmp_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            ir_jmp_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            ir_jmp_q   <= ir_jmp_d;
            count_q    <= count_d;
        end
    end

    assign rom_address  = pc;
    assign ir_valid     = ir_valid_q;
    assign ir           = ir_q;
    assign ir_pc        = ir_pc_q;
    assign ir_jmp_taken = ir_jmp_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 16-word program ROM.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic [3:0]  rom_address;
    logic [15:0] rom_inst;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] ir;
    logic [3:0]  ir_pc;
    logic        ir_jmp_taken;
    logic        redirect_valid = 1'b0;
    logic [3:0]  redirect_pc = '0;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [16];

`ifdef FETCH_PREDECODE_EN
    localparam logic       EXP_JMP   = 1'b1;
    localparam logic [3:0] AFTER_JMP = 4'd8;
`else
    localparam logic       EXP_JMP   = 1'b0;
    localparam logic [3:0] AFTER_JMP = 4'd10;
`endif

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_address];

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .rom_address    (rom_address),
        .rom_inst       (rom_inst),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_jmp_taken   (ir_jmp_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rom[0]  = 16'h1E06; rom[1]  = 16'h1201;
        rom[2]  = 16'h1301; rom[3]  = 16'h2101;
        rom[4]  = 16'h2280; rom[5]  = 16'h3001;
        rom[6]  = 16'hB101; rom[7]  = 16'hF000;
        rom[8]  = 16'hF400; rom[9]  = 16'h8800;
        rom[10] = 16'hE123; rom[11] = 16'h0000;
        rom[12] = 16'hC004; rom[13] = 16'h1111;
        rom[14] = 16'h2222; rom[15] = 16'h3333;

        #1 rst = 1'b1;
        #2;
        chk("rst_valid", ir_valid, 0);
        chk("rst_addr", rom_address, 0);
        chk("rst_ir", ir, 0);
        chk("rst_cnt", fetch_count, 0);
        chk("rst_jmp", ir_jmp_taken, 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_valid", ir_valid, 0);

        // back-to-back stream
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        step();
        chk("s0_pc", ir_pc, 0);
        chk("s0_ir", ir, 16'h1E06);
        chk("s0_valid", ir_valid, 1);
        chk("s0_cnt", fetch_count, 0);
        step();
        chk("s1_pc", ir_pc, 1);
        chk("s1_ir", ir, 16'h1201);
        chk("s1_cnt", fetch_count, 1);
        step();
        chk("s2_pc", ir_pc, 2);
        step();
        chk("s3_pc", ir_pc, 3);
        step();
        chk("s4_pc", ir_pc, 4);
        chk("s4_cnt", fetch_count, 4);

        // stall for three cycles
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", ir_pc, 4);
            chk("st_ir", ir, 16'h2280);
            chk("st_valid", ir_valid, 1);
            chk("st_addr", rom_address, 5);
            chk("st_cnt", fetch_count, 4);
        end
        ir_ready = 1'b1;
        step();
        chk("res_pc", ir_pc, 5);
        chk("res_cnt", fetch_count, 5);

        // redirect backwards to 3, then to 8 while ir_pc=3
        redirect_valid = 1'b1;
        redirect_pc = 4'd3;
        step();
        chk("rd3_valid", ir_valid, 0);
        chk("rd3_addr", rom_address, 3);
        chk("rd3_cnt", fetch_count, 6);
        redirect_valid = 1'b0;
        step();
        chk("rd3_pc", ir_pc, 3);
        chk("rd3_ir", ir, 16'h2101);
        chk("rd3_cnt2", fetch_count, 6);
        redirect_valid = 1'b1;
        redirect_pc = 4'd8;
        step();
        chk("rd8_valid", ir_valid, 0);
        chk("rd8_addr", rom_address, 8);
        chk("rd8_cnt", fetch_count, 7);
        redirect_valid = 1'b0;
        step();
        chk("rd8_pc", ir_pc, 8);
        chk("rd8_ir", ir, 16'hF400);
        chk("rd8_vld", ir_valid, 1);

        // jmp at 9
        step();
        chk("j_pc", ir_pc, 9);
        chk("j_ir", ir, 16'h8800);
        chk("j_taken", ir_jmp_taken, EXP_JMP);
        chk("j_cnt", fetch_count, 8);
        step();
        chk("j_next", ir_pc, AFTER_JMP);
        chk("j_clr", ir_jmp_taken, 0);
        chk("j_vld", ir_valid, 1);
        chk("j_cnt2", fetch_count, 9);

        // wrap from 14
        redirect_valid = 1'b1;
        redirect_pc = 4'd14;
        step();
        chk("w_valid", ir_valid, 0);
        chk("w_cnt", fetch_count, 10);
        redirect_valid = 1'b0;
        step();
        chk("w14", ir_pc, 14);
        chk("w14_cnt", fetch_count, 10);
        step();
        chk("w15", ir_pc, 15);
        chk("w15_cnt", fetch_count, 11);
        step();
        chk("w0", ir_pc, 0);
        chk("w0_cnt", fetch_count, 12);
        step();
        chk("w1", ir_pc, 1);
        chk("w1_cnt", fetch_count, 13);

        // redirect to the current PC re-fetches it
        redirect_valid = 1'b1;
        redirect_pc = 4'd2;
        step();
        chk("same_valid", ir_valid, 0);
        chk("same_addr", rom_address, 2);
        redirect_valid = 1'b0;
        step();
        chk("same_pc", ir_pc, 2);
        chk("same_ir", ir, 16'h1301);
        chk("same_cnt", fetch_count, 14);

        // stall, then async reset mid-operation
        ir_ready = 1'b0;
        step();
        step();
        chk("pre_valid", ir_valid, 1);
        chk("pre_pc", ir_pc, 2);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", ir_valid, 0);
        chk("mrst_addr", rom_address, 0);
        chk("mrst_cnt", fetch_count, 0);
        chk("mrst_ir", ir, 0);
        chk("mrst_irpc", ir_pc, 0);
        fetch_en = 1'b0;
        step();
        rst = 1'b0;

        // drain with fetch_en low
        fetch_en = 1'b1;
        step();
        chk("dr_valid", ir_valid, 1);
        chk("dr_pc", ir_pc, 0);
        fetch_en = 1'b0;
        step();
        chk("dr_hold", ir_valid, 1);
        chk("dr_addr", rom_address, 1);
        ir_ready = 1'b1;
        step();
        chk("dr_done", ir_valid, 0);
        chk("dr_cnt", fetch_count, 1);
        chk("dr_addr2", rom_address, 1);
        step();
        chk("dr_idle", ir_valid, 0);

        // counter saturation
        fetch_en = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("sat_cnt", fetch_count, 16'hFFFF);
        step();
        chk("sat_hold", fetch_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
